cpu_exc_ctrl: RTL and testbench

//  Interrupt/exception initiator for the single-cycle MIPS CPU. Decides when fetch is redirected
//  to the interrupt vector (PCSrc=4) or the exception vector (PCSrc=5), and computes the return

---
 rtl/cpu_exc_ctrl_pkg.sv | 42 ++++
 rtl/cpu_exc_ctrl_irq_pending.sv | 39 +++
 rtl/cpu_exc_ctrl.sv | 108 ++++++++++
 tb/tb_cpu_exc_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_exc_ctrl_pkg.sv
// Shared definitions for the interrupt/exception initiator.
//   PCSrc encodings understood by the PC-source selector, the fixed vector
//   addresses the selector jumps to, the initiator FSM state type and a
//   helper for the "skip the offending instruction" return address.
package cpu_exc_ctrl_pkg;

  localparam logic [2:0] PCS_PC4    = 3'd0;
  localparam logic [2:0] PCS_BRANCH = 3'd1;
  localparam logic [2:0] PCS_JUMP   = 3'd2;
  localparam logic [2:0] PCS_JR     = 3'd3;
  localparam logic [2:0] PCS_ILLOP  = 3'd4;
  localparam logic [2:0] PCS_XADR   = 3'd5;

  localparam logic [31:0] START = 32'h8000_0000;
  localparam logic [31:0] ILLOP = 32'h8000_0004;
  localparam logic [31:0] XADR  = 32'h8000_0008;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_USER  = 2'd1,
    ST_K_IRQ = 2'd2,
    ST_K_EXC = 2'd3
  } exc_state_t;

  // Fixed target address for the vector encodings; anything else resolves
  // to the reset vector so callers never see an undefined address.
  function automatic logic [31:0] vector_addr(input logic [2:0] pcsrc);
    logic [31:0] addr;
    case (pcsrc)
      PCS_ILLOP: addr = ILLOP;
      PCS_XADR:  addr = XADR;
      default:   addr = START;
    endcase
    return addr;
  endfunction

  // pc+4 on the low 31 bits only: the kernel/user bit is never carried into.
  function automatic logic [31:0] epc_skip(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/cpu_exc_ctrl_irq_pending.sv
// exc_irq_pending: interrupt request conditioning.
//   Edge mode latches a rising edge of irq_in until the interrupt is taken;
//   level mode passes irq_in straight through.
// Ports:
//   clk      in   CPU clock
//   reset    in   synchronous active-high reset
//   irq_in   in   raw interrupt request
//   clear    in   interrupt is being taken this cycle
//   pending  out  an interrupt is waiting to be taken
module exc_irq_pending #(
  parameter int IRQ_EDGE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic clear,
  output logic pending
);

  logic irq_d;
  logic pend_q;
  logic rise;

  assign rise = irq_in & ~irq_d;

  // A fresh edge in the same cycle as the clear wins, so no request is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_d  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      irq_d  <= irq_in;
      pend_q <= rise | (pend_q & ~clear);
    end
  end

  assign pending = (IRQ_EDGE != 0) ? pend_q : irq_in;

endmodule

// File: rtl/cpu_exc_ctrl.sv
// cpu_exc_ctrl: interrupt/exception initiator for the single-cycle MIPS CPU.
//   Decides in the same cycle as the executing instruction whether fetch is
//   redirected to the interrupt vector (PCSrc=4) or exception vector (PCSrc=5)
//   and produces the return address for $26. Kernel mode is pc[31]=1.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   pc             PC of the instruction executing this cycle
//   irq_in         timer/peripheral interrupt request
//   undef_inst     decoder flags the current instruction as undefined
//   pcsrc_ovr      0 none, 4 interrupt vector, 5 exception vector
//   exc_take       redirect this cycle
//   kill_wb        suppress RegWrite/MemWrite of the aborted instruction
//   xp_we          write epc into $26
//   epc            return address
//   irq_ack        one-cycle pulse when an interrupt is taken
//   dbl_fault      sticky: undefined instruction while in kernel
//   exc_cnt        saturating count of taken interrupts and exceptions
module cpu_exc_ctrl
  import cpu_exc_ctrl_pkg::*;
#(
  parameter int IRQ_EDGE = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic             irq_in,
  input  logic             undef_inst,
  output logic [2:0]       pcsrc_ovr,
  output logic             exc_take,
  output logic             kill_wb,
  output logic             xp_we,
  output logic [31:0]      epc,
  output logic             irq_ack,
  output logic             dbl_fault,
  output logic [CNT_W-1:0] exc_cnt
);

  exc_state_t state;
  logic       pending;
  logic       can_take;
  logic       take_exc;
  logic       take_irq;

  exc_irq_pending #(
    .IRQ_EDGE(IRQ_EDGE)
  ) u_pending (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .clear  (take_irq),
    .pending(pending)
  );

  // Only a user-mode instruction seen from USER state can be redirected;
  // the undefined-instruction exception has priority and leaves a pending
  // interrupt in place for after the handler returns.
  assign can_take = !reset && (state == ST_USER) && !pc[31];
  assign take_exc = can_take && undef_inst;
  assign take_irq = can_take && pending && !undef_inst;

  // Interrupts abort the instruction (re-executed on return, writes killed);
  // exceptions skip the offender, which writes nothing anyway.
  always_comb begin
    pcsrc_ovr = PCS_PC4;
    epc       = pc;
    if (reset) begin
      epc = 32'h0;
    end else if (take_exc) begin
      pcsrc_ovr = PCS_XADR;
      epc       = epc_skip(pc);
    end else if (take_irq) begin
      pcsrc_ovr = PCS_ILLOP;
    end
  end

  assign exc_take = take_exc | take_irq;
  assign xp_we    = exc_take;
  assign kill_wb  = take_irq;
  assign irq_ack  = take_irq;

  // Mode tracking plus the sticky fault flag and saturating event counter.
  // An undefined instruction that cannot be redirected is a double fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_BOOT;
      dbl_fault <= 1'b0;
      exc_cnt   <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (!pc[31]) state <= ST_USER;
        end
        ST_USER: begin
          if (take_exc)      state <= ST_K_EXC;
          else if (take_irq) state <= ST_K_IRQ;
        end
        ST_K_IRQ, ST_K_EXC: begin
          if (!pc[31]) state <= ST_USER;
        end
        default: state <= ST_BOOT;
      endcase
      if (undef_inst && !can_take) dbl_fault <= 1'b1;
      if (exc_take && (exc_cnt != '1)) exc_cnt <= exc_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_exc_ctrl.sv
// tb_cpu_exc_ctrl: scoreboard bench for cpu_exc_ctrl.
//   Main instance uses edge-triggered interrupts and a 4-bit counter;
//   a second instance exercises level-triggered interrupts out of boot.
module tb_cpu_exc_ctrl;
  import cpu_exc_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0]  pcsrc;
    logic [31:0] epc;
    logic        kill;
    logic        ack;
  } take_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_lvl = 1'b1;
  logic [31:0] pc = 32'h8000_0000;
  logic        irq_in = 1'b0;
  logic        irq_lvl = 1'b0;
  logic        undef_inst = 1'b0;

  logic [2:0]  pcsrc_ovr, l_pcsrc_ovr;
  logic        exc_take, l_exc_take;
  logic        kill_wb, l_kill_wb;
  logic        xp_we, l_xp_we;
  logic [31:0] epc, l_epc;
  logic        irq_ack, l_irq_ack;
  logic        dbl_fault, l_dbl_fault;
  logic [3:0]  exc_cnt;
  logic [7:0]  l_exc_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  take_t q_main[$];
  take_t q_lvl[$];

  always #5 clk = ~clk;

  cpu_exc_ctrl #(.IRQ_EDGE(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .irq_in(irq_in), .undef_inst(undef_inst),
    .pcsrc_ovr(pcsrc_ovr), .exc_take(exc_take), .kill_wb(kill_wb), .xp_we(xp_we),
    .epc(epc), .irq_ack(irq_ack), .dbl_fault(dbl_fault), .exc_cnt(exc_cnt)
  );

  cpu_exc_ctrl #(.IRQ_EDGE(0), .CNT_W(8)) dut_lvl (
    .clk(clk), .reset(reset_lvl), .pc(pc), .irq_in(irq_lvl), .undef_inst(1'b0),
    .pcsrc_ovr(l_pcsrc_ovr), .exc_take(l_exc_take), .kill_wb(l_kill_wb), .xp_we(l_xp_we),
    .epc(l_epc), .irq_ack(l_irq_ack), .dbl_fault(l_dbl_fault), .exc_cnt(l_exc_cnt)
  );

  // Drive one instruction for one cycle; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic [31:0] p, input logic irq, input logic undef);
    pc         = p;
    irq_in     = irq;
    undef_inst = undef;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pushMain(input logic [2:0] pcs, input logic [31:0] e, input logic irq);
    q_main.push_back('{pcsrc: pcs, epc: e, kill: irq, ack: irq});
  endtask

  // One scoreboard step: either a take matched against the queued entry,
  // or an idle cycle where every strobe must be low.
  task automatic scoreTake(input string tag, input bit have_exp, input take_t exp,
                           input logic take, input logic [2:0] pcs, input logic [31:0] e,
                           input logic kill, input logic ack, input logic xpw);
    n_cmp++;
    if (take && !have_exp) begin
      n_bad++;
      $display("[TB] FAIL %s_unexpected_take: got pcsrc=%0d epc=0x%08h, expected no take", tag, pcs, e);
    end else if (!take && have_exp) begin
      n_bad++;
      $display("[TB] FAIL %s_missing_take: got no take, expected pcsrc=%0d epc=0x%08h", tag, exp.pcsrc, exp.epc);
    end else if (take) begin
      if ({pcs, e, kill, ack, xpw} !== {exp.pcsrc, exp.epc, exp.kill, exp.ack, 1'b1}) begin
        n_bad++;
        $display("[TB] FAIL %s_take: got pcsrc=%0d epc=0x%08h kill=%0b ack=%0b xp_we=%0b, expected pcsrc=%0d epc=0x%08h kill=%0b ack=%0b xp_we=1",
                 tag, pcs, e, kill, ack, xpw, exp.pcsrc, exp.epc, exp.kill, exp.ack);
      end
    end else if ({pcs, kill, ack, xpw} !== 6'b0) begin
      n_bad++;
      $display("[TB] FAIL %s_idle: got pcsrc=%0d kill=%0b ack=%0b xp_we=%0b, expected all 0", tag, pcs, kill, ack, xpw);
    end
  endtask

  // Monitors: sample mid-cycle, pop an expectation whenever one is queued.
  always @(negedge clk) begin
    take_t e;
    bit    have;
    have = (q_main.size() != 0);
    e    = have ? q_main.pop_front() : '0;
    scoreTake("main", have, e, exc_take, pcsrc_ovr, epc, kill_wb, irq_ack, xp_we);
  end

  always @(negedge clk) begin
    take_t e;
    bit    have;
    have = (q_lvl.size() != 0);
    e    = have ? q_lvl.pop_front() : '0;
    scoreTake("lvl", have, e, l_exc_take, l_pcsrc_ovr, l_epc, l_kill_wb, l_irq_ack, l_xp_we);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cnt", 32'(exc_cnt), 32'd0);
    checkOutput("reset_dbl", 32'(dbl_fault), 32'd0);
    checkOutput("reset_state", 32'(dut.state), 32'(ST_BOOT));

    // Level-triggered interrupt out of boot.
    reset = 1'b0;
    reset_lvl = 1'b0;
    irq_lvl = 1'b1;
    applyStimulus(32'h8000_0000, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 1'b0, 1'b0);
    applyStimulus(32'h0000_0040, 1'b0, 1'b0);
    q_lvl.push_back('{pcsrc: 3'd4, epc: 32'h40, kill: 1'b1, ack: 1'b1});
    applyStimulus(32'h0000_0040, 1'b0, 1'b0);
    checkOutput("lvl_cnt", 32'(l_exc_cnt), 32'd1);
    checkOutput("lvl_state", 32'(dut_lvl.state), 32'(ST_K_IRQ));
    applyStimulus(32'h8000_0004, 1'b0, 1'b0);
    irq_lvl = 1'b0;
    reset_lvl = 1'b1;

    // Undefined instruction in user mode.
    pushMain(3'd5, 32'h104, 1'b0);
    applyStimulus(32'h0000_0100, 1'b0, 1'b1);
    checkOutput("exc_state", 32'(dut.state), 32'(ST_K_EXC));
    checkOutput("exc_cnt1", 32'(exc_cnt), 32'd1);
    applyStimulus(32'h8000_0008, 1'b0, 1'b0);
    applyStimulus(32'h0000_0104, 1'b0, 1'b0);

    // Exception and irq edge together: exception first, interrupt after return.
    pushMain(3'd5, 32'h104, 1'b0);
    applyStimulus(32'h0000_0100, 1'b1, 1'b1);
    applyStimulus(32'h8000_0008, 1'b1, 1'b0);
    applyStimulus(32'h0000_0104, 1'b0, 1'b0);
    pushMain(3'd4, 32'h104, 1'b1);
    applyStimulus(32'h0000_0104, 1'b0, 1'b0);
    checkOutput("irq_state", 32'(dut.state), 32'(ST_K_IRQ));
    checkOutput("exc_cnt3", 32'(exc_cnt), 32'd3);

    // Kernel-mode undefined instruction and held edge; edge during a take.
    applyStimulus(32'h8000_0010, 1'b1, 1'b1);
    checkOutput("dbl_set", 32'(dbl_fault), 32'd1);
    applyStimulus(32'h8000_0014, 1'b0, 1'b0);
    applyStimulus(32'h0000_0104, 1'b0, 1'b0);
    pushMain(3'd4, 32'h104, 1'b1);
    applyStimulus(32'h0000_0104, 1'b1, 1'b0);
    applyStimulus(32'h8000_0004, 1'b1, 1'b0);
    applyStimulus(32'h0000_0108, 1'b0, 1'b0);
    pushMain(3'd4, 32'h108, 1'b1);
    applyStimulus(32'h0000_0108, 1'b0, 1'b0);
    applyStimulus(32'h0000_0108, 1'b0, 1'b0);
    applyStimulus(32'h0000_010C, 1'b0, 1'b0);
    checkOutput("dbl_sticky", 32'(dbl_fault), 32'd1);

    // Return address wraps on the low 31 bits.
    pushMain(3'd5, 32'h0000_0000, 1'b0);
    applyStimulus(32'h7FFF_FFFC, 1'b0, 1'b1);
    applyStimulus(32'h8000_0008, 1'b0, 1'b0);
    applyStimulus(32'h0000_0200, 1'b0, 1'b0);

    // Reset in K_EXC with an interrupt pending.
    pushMain(3'd5, 32'h204, 1'b0);
    applyStimulus(32'h0000_0200, 1'b1, 1'b1);
    checkOutput("pre_rst_pend", 32'(dut.u_pending.pending), 32'd1);
    checkOutput("pre_rst_cnt", 32'(exc_cnt), 32'd7);
    reset = 1'b1;
    applyStimulus(32'h0000_0300, 1'b1, 1'b1);
    checkOutput("rst_epc", epc, 32'h0);
    checkOutput("rst_take", 32'({exc_take, pcsrc_ovr}), 32'd0);
    checkOutput("rst_cnt", 32'(exc_cnt), 32'd0);
    checkOutput("rst_dbl", 32'(dbl_fault), 32'd0);
    checkOutput("rst_state", 32'(dut.state), 32'(ST_BOOT));
    reset = 1'b0;
    applyStimulus(32'h0000_0300, 1'b0, 1'b0);
    applyStimulus(32'h0000_0300, 1'b0, 1'b0);
    checkOutput("post_rst_cnt", 32'(exc_cnt), 32'd0);

    // Counter saturation.
    for (int i = 0; i < 18; i++) begin
      pushMain(3'd5, 32'h304, 1'b0);
      applyStimulus(32'h0000_0300, 1'b0, 1'b1);
      applyStimulus(32'h8000_0008, 1'b0, 1'b0);
      applyStimulus(32'h0000_0300, 1'b0, 1'b0);
    end
    checkOutput("cnt_sat", 32'(exc_cnt), 32'd15);

    @(negedge clk);
    checkOutput("queue_drained", 32'(q_main.size() + q_lvl.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
